// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, timeout default and memory-interface FSM states
package cpu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_TIMEOUT_CYC = 15;
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;
endpackage

// File: rtl/mdr_unit.sv
// mdr_unit: memory data register with bus/memory source select
module mdr_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_bus,
  input  logic         ld_mem,
  input  logic [W-1:0] bus,
  input  logic [W-1:0] rdata,
  output logic [W-1:0] mdr
);
  always_ff @(posedge clk or posedge rst)
    if (rst) mdr <= '0;
    else if (ld_bus || ld_mem) mdr <= ld_mem ? rdata : bus;
endmodule

// File: rtl/mem_interface.sv
// mem_interface: MAR/MDR owner sequencing single-word RAM reads/writes over req/ack with timeout
module mem_interface
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] BusMuxInMAR,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] mar, mdr;
  logic idle, rd_cmd, wr_cmd, acc, tmo;
  assign idle = state == IDLE;
  assign rd_cmd = idle && Read && MDRin;
  assign wr_cmd = idle && Write && !rd_cmd;
  assign acc = rd_cmd || wr_cmd;
  // ack on the limit edge still counts as success
  assign tmo = !idle && !mem_ack && cnt == CW'(TIMEOUT_CYC - 1);
  always_comb
    state_n = rd_cmd ? RD : wr_cmd ? WR : (!idle && (mem_ack || tmo)) ? IDLE : state;
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      state <= IDLE;
      cnt <= '0;
      mar <= '0;
      err <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= !idle && mem_ack;
      cnt <= acc ? '0 : (!idle && !mem_ack) ? cnt + CW'(1) : cnt;
      err <= acc ? 1'b0 : tmo ? 1'b1 : err;
      if (MARin && idle) mar <= BusMuxOut;
    end
  mdr_unit #(.W(DATA_W)) u_mdr (
    .clk(clock),
    .rst(clear),
    .ld_bus(idle && MDRin && !Read),
    .ld_mem(state == RD && mem_ack),
    .bus(BusMuxOut),
    .rdata(mem_rdata),
    .mdr(mdr)
  );
  assign BusMuxInMAR = mar;
  assign BusMuxInMDR = mdr;
  assign mem_addr = mar[ADDR_W-1:0];
  assign mem_wdata = mdr;
  assign mem_rd_req = state == RD;
  assign mem_wr_req = state == WR;
  assign busy = !idle;
endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: directed checks of reset, read, write, timeout and hazard handling
module tb_mem_interface;
  logic clock = 0, clear = 1;
  logic [31:0] BusMuxOut = 0, mem_rdata = 0;
  logic MARin = 0, MDRin = 0, Read = 0, Write = 0, mem_ack = 0;
  logic [31:0] BusMuxInMAR, BusMuxInMDR, mem_wdata;
  logic [8:0] mem_addr;
  logic mem_rd_req, mem_wr_req, busy, done, err;
  int n_run = 0, n_fail = 0;

  mem_interface dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .BusMuxInMAR(BusMuxInMAR), .BusMuxInMDR(BusMuxInMDR),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_rd"}, 32'(mem_rd_req), 0);
    chk({tag, "_wr"}, 32'(mem_wr_req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_mar"}, BusMuxInMAR, 0);
    chk({tag, "_mdr"}, BusMuxInMDR, 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
  endtask

  initial begin
    step();
    idle_outs("rst");
    clear = 0;
    // 1: async clear mid-read
    MARin = 1; BusMuxOut = 32'h33; step();
    MARin = 0; Read = 1; MDRin = 1; step();
    Read = 0; MDRin = 0;
    chk("t1_req", 32'(mem_rd_req), 1);
    chk("t1_addr", 32'(mem_addr), 32'h33);
    #2 clear = 1;
    #1 idle_outs("t1_clr");
    step(); clear = 0;
    Read = 1; MDRin = 1; step();
    Read = 0; MDRin = 0;
    chk("t1_again_req", 32'(mem_rd_req), 1);
    mem_ack = 1; mem_rdata = 32'h1111; step();
    mem_ack = 0;
    chk("t1_done", 32'(done), 1);
    chk("t1_mdr", BusMuxInMDR, 32'h1111);
    // 2: read with ack after 3 cycles
    MARin = 1; BusMuxOut = 32'h05; step();
    MARin = 0; Read = 1; MDRin = 1; step();
    Read = 0; MDRin = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_req", 32'(mem_rd_req), 1);
      chk("t2_addr", 32'(mem_addr), 32'h05);
      chk("t2_done_lo", 32'(done), 0);
      if (i == 2) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
      step();
    end
    mem_ack = 0; mem_rdata = 0;
    chk("t2_req_off", 32'(mem_rd_req), 0);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_done", 32'(done), 1);
    chk("t2_mdr", BusMuxInMDR, 32'hDEADBEEF);
    step();
    chk("t2_done_pulse", 32'(done), 0);
    // 3: write with ack after 1 cycle
    MDRin = 1; BusMuxOut = 32'h12345678; step();
    MDRin = 0; MARin = 1; BusMuxOut = 32'h1FF; step();
    MARin = 0; Write = 1; step();
    Write = 0;
    chk("t3_wr", 32'(mem_wr_req), 1);
    chk("t3_rd", 32'(mem_rd_req), 0);
    chk("t3_wdata", mem_wdata, 32'h12345678);
    chk("t3_addr", 32'(mem_addr), 32'h1FF);
    mem_ack = 1; step();
    mem_ack = 0;
    chk("t3_wr_off", 32'(mem_wr_req), 0);
    chk("t3_done", 32'(done), 1);
    step();
    chk("t3_done_pulse", 32'(done), 0);
    // 4: read timeout, then write clears err
    Read = 1; MDRin = 1; step();
    Read = 0; MDRin = 0;
    for (int i = 0; i < 15; i++) begin
      chk("t4_req", 32'(mem_rd_req), 1);
      step();
    end
    chk("t4_req_off", 32'(mem_rd_req), 0);
    chk("t4_err", 32'(err), 1);
    chk("t4_done", 32'(done), 0);
    chk("t4_mdr", BusMuxInMDR, 32'h12345678);
    step();
    chk("t4_err_sticky", 32'(err), 1);
    Write = 1; step();
    Write = 0;
    chk("t4_err_clr", 32'(err), 0);
    chk("t4_wr", 32'(mem_wr_req), 1);
    mem_ack = 1; step();
    mem_ack = 0;
    chk("t4_wr_done", 32'(done), 1);
    // 5: hazards while busy, ack on timeout edge
    Read = 1; MDRin = 1; step();
    Read = 0; MDRin = 0;
    MARin = 1; BusMuxOut = 32'hAA; step();
    MARin = 0; MDRin = 1; step();
    MDRin = 0; BusMuxOut = 0;
    chk("t5_mar", BusMuxInMAR, 32'h1FF);
    chk("t5_mdr", BusMuxInMDR, 32'h12345678);
    for (int i = 0; i < 12; i++) step();
    chk("t5_req", 32'(mem_rd_req), 1);
    mem_ack = 1; mem_rdata = 32'h0BADF00D; step();
    mem_ack = 0; mem_rdata = 0;
    chk("t5_done", 32'(done), 1);
    chk("t5_err", 32'(err), 0);
    chk("t5_mdr_rd", BusMuxInMDR, 32'h0BADF00D);
    chk("t5_mar_end", BusMuxInMAR, 32'h1FF);
    // 6: read and write together, read wins
    Read = 1; MDRin = 1; Write = 1; step();
    Read = 0; MDRin = 0; Write = 0;
    for (int i = 0; i < 2; i++) begin
      chk("t6_rd", 32'(mem_rd_req), 1);
      chk("t6_wr", 32'(mem_wr_req), 0);
      step();
    end
    mem_ack = 1; mem_rdata = 32'h600D; step();
    mem_ack = 0;
    chk("t6_done", 32'(done), 1);
    chk("t6_wr_end", 32'(mem_wr_req), 0);
    chk("t6_mdr", BusMuxInMDR, 32'h600D);
    // ack in idle is ignored
    mem_ack = 1; mem_rdata = 32'hFFFF; step();
    mem_ack = 0;
    chk("idle_ack_done", 32'(done), 0);
    chk("idle_ack_mdr", BusMuxInMDR, 32'h600D);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
